// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
//   Groups the serial line and the byte-delivery outputs of the UART receiver.
//
//   Signals:
//     rx_serial    serial line into the receiver (idle high)
//     rx_data      last received byte
//     rx_valid     one-cycle strobe, rx_data valid in the same cycle
//     rx_busy      receiver is inside a frame
//     rx_frame_err one-cycle strobe on a bad stop bit
//
//   Modports:
//     slave  - the receiver (drives the outputs, reads the line)
//     master - the surrounding logic (drives the line, consumes bytes)
// ----------------------------------------------------------------------------
interface uart_rx_if;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;

    modport slave (
        input  rx_serial,
        output rx_data,
        output rx_valid,
        output rx_busy,
        output rx_frame_err
    );

    modport master (
        output rx_serial,
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  rx_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   8N1 serial receiver. Oversamples the line at the system clock, finds the
//   start bit, samples every bit at mid-bit and delivers each byte with a
//   one-cycle valid strobe.
//
//   Parameters:
//     CLKS_PER_BIT  clock cycles per serial bit (4..65535)
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     rx_if  uart_rx_if.slave: rx_serial in; rx_data, rx_valid, rx_busy,
//            rx_frame_err out
//
//   Build option:
//     UART_RX_FRAME_CHECK_EN  when defined, a low stop bit raises
//                             rx_frame_err instead of rx_valid. When not
//                             defined, rx_frame_err is tied low and every
//                             frame ends with rx_valid.
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave rx_if
);

    // Start bit is checked at its middle; data/stop bits one full bit apart.
    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
`ifdef UART_RX_FRAME_CHECK_EN
    logic        ferr_q, ferr_d;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level so reset
    // release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_if.rx_serial;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef UART_RX_FRAME_CHECK_EN
            ferr_q  <= ferr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
        ferr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (!sync2_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q < HALF) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = 16'd0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d = sync2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q < LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d          = 16'd0;
                    data_d[idx_q]  = sync2_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q < LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d   = 16'd0;
                    state_d = S_CLEANUP;
`ifdef UART_RX_FRAME_CHECK_EN
                    if (sync2_q) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
`else
                    valid_d = 1'b1;
`endif
                end
            end
            S_CLEANUP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign rx_if.rx_busy  = (state_q != S_IDLE);
`ifdef UART_RX_FRAME_CHECK_EN
    assign rx_if.rx_frame_err = ferr_q;
`else
    assign rx_if.rx_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int CPB   = 16;
    localparam int CPB_L = 104;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if ifa ();
    uart_rx_if ifb ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (ifa.slave)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_L)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (ifb.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder for dut_a, sampled on the falling edge.
    int unsigned v_cyc[$];
    logic [7:0]  v_dat[$];
    int unsigned e_cyc[$];
    int unsigned rise_cyc = 0;
    int unsigned fall_cyc = 0;
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        if (ifa.rx_valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(ifa.rx_data);
        end
        if (ifa.rx_frame_err === 1'b1) e_cyc.push_back(cyc);
        if (ifa.rx_busy === 1'b1 && !busy_prev) rise_cyc = cyc;
        if (ifa.rx_busy === 1'b0 && busy_prev) fall_cyc = cyc;
        busy_prev = (ifa.rx_busy === 1'b1);
    end

    // Event recorder for dut_b.
    int unsigned vb_cyc = 0;
    logic [7:0]  vb_dat = 8'h00;
    int          vb_cnt = 0;

    always @(negedge clk) begin
        if (ifb.rx_valid === 1'b1) begin
            vb_cyc = cyc;
            vb_dat = ifb.rx_data;
            vb_cnt = vb_cnt + 1;
        end
    end

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        ifa.rx_serial = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, output int unsigned t0);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        ifa.rx_serial = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        v_cyc.delete();
        v_dat.delete();
        e_cyc.delete();
    endtask

    task automatic test_reset();
        ifa.rx_serial = 1'b1;
        ifb.rx_serial = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ifa.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", ifa.rx_data);
        end
        checks++;
        if (ifa.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", ifa.rx_valid);
        end
        checks++;
        if (ifa.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", ifa.rx_busy);
        end
        checks++;
        if (ifa.rx_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr: got %b expected 0", ifa.rx_frame_err);
        end
        rst_n = 1'b1;
        idle(5);
        $display("test_reset done");
    endtask

    task automatic test_single();
        int unsigned t0;
        clear_mon();
        send_byte(8'hA5, 1'b1, t0);
        idle(20);
        checks++;
        if (v_cyc.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d pulses expected 1", v_cyc.size());
        end
        if (v_cyc.size() >= 1) begin
            checks++;
            if (v_cyc[0] != t0 + 155) begin
                errors++;
                $display("FAIL single_edge: got cycle %0d expected %0d", v_cyc[0], t0 + 155);
            end
            checks++;
            if (v_dat[0] !== 8'hA5) begin
                errors++;
                $display("FAIL single_data: got %h expected a5", v_dat[0]);
            end
        end
        checks++;
        if (rise_cyc != t0 + 3) begin
            errors++;
            $display("FAIL busy_rise: got cycle %0d expected %0d", rise_cyc, t0 + 3);
        end
        checks++;
        if (fall_cyc != t0 + 156) begin
            errors++;
            $display("FAIL busy_fall: got cycle %0d expected %0d", fall_cyc, t0 + 156);
        end
        checks++;
        if (e_cyc.size() != 0) begin
            errors++;
            $display("FAIL single_ferr: got %0d pulses expected 0", e_cyc.size());
        end
        $display("test_single byte a5 done");
    endtask

    task automatic test_back_to_back();
        int unsigned t0, t1;
        clear_mon();
        send_byte(8'h00, 1'b1, t0);
        send_byte(8'hFF, 1'b1, t1);
        idle(20);
        checks++;
        if (v_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses expected 2", v_cyc.size());
        end
        if (v_cyc.size() == 2) begin
            checks++;
            if (v_cyc[1] - v_cyc[0] != 160) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d expected 160", v_cyc[1] - v_cyc[0]);
            end
            checks++;
            if (v_dat[0] !== 8'h00) begin
                errors++;
                $display("FAIL b2b_data0: got %h expected 00", v_dat[0]);
            end
            checks++;
            if (v_dat[1] !== 8'hFF) begin
                errors++;
                $display("FAIL b2b_data1: got %h expected ff", v_dat[1]);
            end
        end
        $display("test_back_to_back 00 ff done");
    endtask

    task automatic test_glitch();
        int unsigned t0;
        clear_mon();
        t0 = cyc;
        ifa.rx_serial = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(40);
        checks++;
        if (v_cyc.size() != 0 || e_cyc.size() != 0) begin
            errors++;
            $display("FAIL glitch_pulses: got valid=%0d ferr=%0d expected 0 0", v_cyc.size(), e_cyc.size());
        end
        checks++;
        if (rise_cyc != t0 + 3) begin
            errors++;
            $display("FAIL glitch_rise: got cycle %0d expected %0d", rise_cyc, t0 + 3);
        end
        checks++;
        if (fall_cyc != t0 + 11) begin
            errors++;
            $display("FAIL glitch_fall: got cycle %0d expected %0d", fall_cyc, t0 + 11);
        end
        $display("test_glitch done");
    endtask

    task automatic test_frame_err();
        int unsigned t0;
        clear_mon();
        send_byte(8'h3C, 1'b0, t0);
        idle(40);
`ifdef UART_RX_FRAME_CHECK_EN
        checks++;
        if (e_cyc.size() != 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d pulses expected 1", e_cyc.size());
        end
        if (e_cyc.size() >= 1) begin
            checks++;
            if (e_cyc[0] != t0 + 155) begin
                errors++;
                $display("FAIL ferr_edge: got cycle %0d expected %0d", e_cyc[0], t0 + 155);
            end
        end
        checks++;
        if (v_cyc.size() != 0) begin
            errors++;
            $display("FAIL ferr_valid: got %0d pulses expected 0", v_cyc.size());
        end
`else
        checks++;
        if (v_cyc.size() != 1) begin
            errors++;
            $display("FAIL nochk_count: got %0d pulses expected 1", v_cyc.size());
        end
        if (v_cyc.size() >= 1) begin
            checks++;
            if (v_dat[0] !== 8'h3C || v_cyc[0] != t0 + 155) begin
                errors++;
                $display("FAIL nochk_data: got %h at %0d expected 3c at %0d", v_dat[0], v_cyc[0], t0 + 155);
            end
        end
        checks++;
        if (e_cyc.size() != 0) begin
            errors++;
            $display("FAIL nochk_ferr: got %0d pulses expected 0", e_cyc.size());
        end
`endif
        $display("test_frame_err byte 3c done");
    endtask

    task automatic test_reset_mid();
        int unsigned t0;
        logic [7:0]  partial;
        partial = 8'h5A;
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        ifa.rx_serial = partial[4];
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.rx_busy !== 1'b0 || ifa.rx_data !== 8'h00 || ifa.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b data=%h valid=%b expected 0 00 0",
                     ifa.rx_busy, ifa.rx_data, ifa.rx_valid);
        end
        ifa.rx_serial = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        send_byte(8'hC3, 1'b1, t0);
        idle(20);
        checks++;
        if (v_cyc.size() != 1) begin
            errors++;
            $display("FAIL midreset_count: got %0d pulses expected 1", v_cyc.size());
        end
        if (v_cyc.size() >= 1) begin
            checks++;
            if (v_dat[0] !== 8'hC3) begin
                errors++;
                $display("FAIL midreset_data: got %h expected c3", v_dat[0]);
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_loopback();
        int unsigned t;
        clear_mon();
        for (int b = 0; b < 256; b++) send_byte(8'(b), 1'b1, t);
        idle(20);
        checks++;
        if (v_cyc.size() != 256) begin
            errors++;
            $display("FAIL loop_count: got %0d pulses expected 256", v_cyc.size());
        end
        for (int i = 0; i < v_dat.size(); i++) begin
            checks++;
            if (v_dat[i] !== 8'(i)) begin
                errors++;
                $display("FAIL loop_data[%0d]: got %h expected %h", i, v_dat[i], 8'(i));
            end
        end
        checks++;
        if (e_cyc.size() != 0) begin
            errors++;
            $display("FAIL loop_ferr: got %0d pulses expected 0", e_cyc.size());
        end
        $display("test_loopback 256 bytes done");
    endtask

    task automatic drive_bit_b(input logic b);
        ifb.rx_serial = b;
        repeat (CPB_L) @(posedge clk);
        #1;
    endtask

    task automatic test_cpb104();
        int unsigned t0;
        logic [7:0]  d;
        d      = 8'h96;
        vb_cnt = 0;
        t0     = cyc;
        drive_bit_b(1'b0);
        for (int i = 0; i < 8; i++) drive_bit_b(d[i]);
        drive_bit_b(1'b1);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (vb_cnt != 1) begin
            errors++;
            $display("FAIL cpb104_count: got %0d pulses expected 1", vb_cnt);
        end
        checks++;
        if (vb_cyc != t0 + 991) begin
            errors++;
            $display("FAIL cpb104_edge: got cycle %0d expected %0d", vb_cyc, t0 + 991);
        end
        checks++;
        if (vb_dat !== 8'h96) begin
            errors++;
            $display("FAIL cpb104_data: got %h expected 96", vb_dat);
        end
        $display("test_cpb104 byte 96 done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_loopback();
        test_cpb104();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
